// File: rtl/hack_cpu_mc_if.sv
// Fetch and data-memory handshake bundle between the multi-cycle Hack core and its ROM/RAM.
interface hack_cpu_mc_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15
);
  logic [15:0]       instruction;
  logic              instr_valid;
  logic              instr_req;
  logic [ADDR_W-1:0] instr_addr;
  logic [DATA_W-1:0] inM;
  logic              mem_ready;
  logic              rd_req;
  logic              writeM;
  logic [ADDR_W-1:0] addressM;
  logic [DATA_W-1:0] outM;

  modport master (
    output instr_req, instr_addr, rd_req, writeM, addressM, outM,
    input  instruction, instr_valid, inM, mem_ready
  );

  modport slave (
    input  instr_req, instr_addr, rd_req, writeM, addressM, outM,
    output instruction, instr_valid, inM, mem_ready
  );
endinterface

// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU with handshaked instruction fetch and data memory.
// Optional HACK_CPU_MC_PERF_CNT_EN adds retired-instruction and stall-cycle counters.
module hack_cpu_mc #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  hack_cpu_mc_if.master     bus,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] D,
`ifdef HACK_CPU_MC_PERF_CNT_EN
  output logic [31:0]       retired_cnt,
  output logic [31:0]       stall_cnt,
`endif
  output logic              aluNegative
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    MEM_RD = 2'd2,
    MEM_WR = 2'd3
  } state_t;

  state_t            state, state_next;
  logic [15:0]       ir, ir_next;
  logic [DATA_W-1:0] a_old, a_old_next;
  logic [DATA_W-1:0] out_reg, out_next;
  logic [DATA_W-1:0] a_next, d_next;
  logic [ADDR_W-1:0] pc_next, pc_inc;
  logic              neg_next;
  logic              commit;
  logic              retire;
  logic              instr_req_c, rd_req_c, write_c;

  logic [DATA_W-1:0] alu_x, alu_y, alu_sum, alu_out;
  logic              alu_zr, alu_ng, jump;

  // Hack ALU; the a-bit chooses memory data over the A value snapshotted at fetch
  always_comb begin
    alu_x = D;
    alu_y = ir[12] ? bus.inM : a_old;
    if (ir[11]) alu_x = '0;
    if (ir[10]) alu_x = ~alu_x;
    if (ir[9])  alu_y = '0;
    if (ir[8])  alu_y = ~alu_y;
    alu_sum = ir[7] ? (alu_x + alu_y) : (alu_x & alu_y);
    alu_out = ir[6] ? ~alu_sum : alu_sum;
    alu_zr  = (alu_out == '0);
    alu_ng  = alu_out[DATA_W-1];
    jump    = (ir[2] & alu_ng) | (ir[1] & alu_zr) | (ir[0] & ~alu_ng & ~alu_zr);
  end

  assign pc_inc = pc + ADDR_W'(1);

  always_comb begin
    state_next  = state;
    ir_next     = ir;
    a_old_next  = a_old;
    out_next    = out_reg;
    a_next      = A;
    d_next      = D;
    pc_next     = pc;
    neg_next    = aluNegative;
    commit      = 1'b0;
    retire      = 1'b0;
    instr_req_c = 1'b0;
    rd_req_c    = 1'b0;
    write_c     = 1'b0;

    case (state)
      FETCH: begin
        instr_req_c = 1'b1;
        if (bus.instr_valid) begin
          ir_next    = bus.instruction;
          a_old_next = A;
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (!ir[15]) begin
          a_next     = {{(DATA_W-15){1'b0}}, ir[14:0]};
          pc_next    = pc_inc;
          retire     = 1'b1;
          state_next = FETCH;
        end else if (ir[12]) begin
          state_next = MEM_RD;
        end else begin
          commit = 1'b1;
        end
      end
      MEM_RD: begin
        rd_req_c = 1'b1;
        if (bus.mem_ready) commit = 1'b1;
      end
      MEM_WR: begin
        write_c = 1'b1;
        if (bus.mem_ready) begin
          retire     = 1'b1;
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase

    // A write to M is deferred to MEM_WR, so retirement happens there instead
    if (commit) begin
      if (ir[5]) a_next = alu_out;
      if (ir[4]) d_next = alu_out;
      pc_next  = jump ? a_old[ADDR_W-1:0] : pc_inc;
      neg_next = alu_ng;
      if (ir[3]) begin
        out_next   = alu_out;
        state_next = MEM_WR;
      end else begin
        retire     = 1'b1;
        state_next = FETCH;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= FETCH;
      ir          <= '0;
      a_old       <= '0;
      out_reg     <= '0;
      A           <= '0;
      D           <= '0;
      pc          <= '0;
      aluNegative <= 1'b0;
    end else begin
      state       <= state_next;
      ir          <= ir_next;
      a_old       <= a_old_next;
      out_reg     <= out_next;
      A           <= a_next;
      D           <= d_next;
      pc          <= pc_next;
      aluNegative <= neg_next;
    end
  end

  // Requests are gated by reset so they drop the instant reset asserts
  assign bus.instr_req  = instr_req_c & reset;
  assign bus.rd_req     = rd_req_c & reset;
  assign bus.writeM     = write_c & reset;
  assign bus.instr_addr = pc;
  assign bus.addressM   = a_old[ADDR_W-1:0];
  assign bus.outM       = out_reg;

`ifdef HACK_CPU_MC_PERF_CNT_EN
  logic stall;
  assign stall = (instr_req_c & ~bus.instr_valid) |
                 ((rd_req_c | write_c) & ~bus.mem_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (retire) retired_cnt <= retired_cnt + 32'd1;
      if (stall)  stall_cnt   <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/hack_cpu_mc.md
Name: hack_cpu_mc

Overview:
- Parametrised multi-cycle successor to the single-cycle Hack CPU.
- Executes the standard Hack instruction set over a DATA_W-bit datapath with an ADDR_W-bit program counter.
- Instruction fetch and data memory sit behind request/ready handshakes, so the core tolerates wait-stated ROM and RAM.
- Exposes A, D, pc and the ALU negative flag for debug and bench visibility.

Parameters:
- DATA_W, 16: width of the A and D registers, the ALU, inM and outM; must be at least 16.
- ADDR_W, 15: width of pc, instr_addr and addressM; must be at most DATA_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- instruction  in  16  fetched instruction word, sampled when instr_req and instr_valid are both 1.
- instr_valid  in  1  instruction word valid.
- instr_req  out  1  fetch request.
- instr_addr  out  ADDR_W  fetch address; always equals pc.
- inM  in  DATA_W  memory read data, sampled when rd_req and mem_ready are both 1.
- mem_ready  in  1  data memory accepts a write or returns read data this cycle.
- rd_req  out  1  data read request.
- writeM  out  1  data write request.
- addressM  out  ADDR_W  data address, equal to A[ADDR_W-1:0] as latched at EXEC entry.
- outM  out  DATA_W  write data.
- pc  out  ADDR_W  program counter.
- A  out  DATA_W  A register.
- D  out  DATA_W  D register.
- aluNegative  out  1  MSB of the most recent ALU result.

Behaviour:
- Reset (reset=0, asynchronous): pc=0, A=0, D=0, IR=0, aluNegative=0, state=FETCH. All request outputs are forced to 0 while reset is held. Asserting reset mid-transaction abandons the transaction; no partial register update occurs.
- FETCH:
  - instr_req=1.
  - On instr_valid=1: latch IR, capture A_old=A, go to EXEC.
- EXEC:
  - A-instruction (IR[15]=0): A <= zero-extended IR[14:0]; pc <= pc+1; go to FETCH.
  - C-instruction with a-bit IR[12]=0: ALU operates on D and A_old. Commit (see below).
  - C-instruction with a-bit IR[12]=1: go to MEM_RD.
- MEM_RD:
  - rd_req=1, addressM=A_old.
  - On mem_ready=1: ALU operates on D and inM (same cycle, no extra register). Commit.
- Commit:
  - Destination bits IR[5:3] map to A, D, M.
  - If d1: A <= result. If d2: D <= result.
  - Jump bits IR[2:0] are lt, eq, gt, evaluated on the DATA_W-bit result. Jump taken: pc <= A_old[ADDR_W-1:0]. Not taken: pc <= pc+1, wrapping modulo 2^ADDR_W.
  - aluNegative <= result[DATA_W-1].
  - If d3: outM_reg <= result, go to MEM_WR. Otherwise go to FETCH.
- MEM_WR:
  - writeM=1, addressM=A_old, outM=outM_reg. These are held stable until mem_ready=1, then go to FETCH.
  - Writes use A_old even when the same instruction also updates A (e.g. AM=M+1).
- ALU: Hack semantics (zx, nx, zy, ny, f, no = IR[11:6]) over DATA_W bits. f=1 selects addition with the carry discarded; f=0 selects AND. The zero flag (zr) is set when the result is all zeros; the negative flag (ng) is the result MSB.
- Request outputs are 0 in every state not listed for them. rd_req and writeM are never asserted together.
- Minimum latency per instruction:
  - A-instruction: 2 cycles.
  - C-instruction without M access: 2 cycles.
  - C-instruction reading M: 3 cycles.
  - Add 1 cycle for a write to M.
  - Each wait cycle on instr_valid or mem_ready adds 1 cycle.
- IR[14:13] are ignored.

Optional Feature:
- Macro: HACK_CPU_MC_PERF_CNT_EN.
- Enabled: adds outputs retired_cnt [31:0] and stall_cnt [31:0].
  - retired_cnt increments once per instruction on its FETCH return.
  - stall_cnt increments on every cycle with instr_req=1 and instr_valid=0, or with (rd_req|writeM)=1 and mem_ready=0.
  - Both counters are cleared by reset and wrap at 2^32.
- Disabled: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then @16 (0x0010) with instr_valid always 1 -> A=0x0010, pc=1 after 2 cycles; instr_req=0 while reset=0.
- @16; D=A (0xEC10) -> D=0x0010, pc=2, writeM never asserted.
- @16; M=D (0xE308) with mem_ready delayed 3 cycles -> writeM=1 for 4 cycles with addressM=16 and outM=0x0010 held stable; pc=2 afterwards.
- inM=0xFFFF, @5; D=M (0xFC10) -> rd_req=1 with addressM=5; D=0xFFFF, aluNegative=1.
- D=0; @7; D;JEQ (0xE302) -> pc=7. Repeat with D=1 -> pc advances by 1.
- AM=M+1 (0xFDE8) with A=3, inM=9 -> write to address 3 with data 0x000A; A=0x000A afterwards. Assert reset mid-MEM_WR -> writeM drops immediately, pc=0.
